// File: rtl/debouncer_classifier_n.sv
// Multi-channel tyre-sensor debouncer: synchronise, glitch-filter, classify
// each filtered pulse by length and keep a shared saturating car total.
module debouncer_classifier_n #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 2,
    parameter int CNT_W       = 4,
    parameter int MIN_LEN     = 2,
    parameter int CAR_MIN     = 6,
    parameter int MAX_LEN     = 10,
    parameter int TOT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH-1:0]     in,
    input  logic              cnt_clr,
    output logic [CH-1:0]     db_out,
    output logic [CH-1:0]     det_valid,
    output logic [2*CH-1:0]   det_class,
    output logic [CH-1:0]     stuck,
    output logic [TOT_W-1:0]  car_total
);

    localparam int SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam int PW = $clog2(CH + 1);
    localparam logic [SW-1:0]  STAB_LAST = SW'(STABLE_CNT - 1);
    localparam logic [TOT_W:0] TOT_MAX   = {1'b0, {TOT_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, MEAS, FAULT} state_t;

    logic [SYNC_STAGES-1:0] sync_q  [CH];
    logic [SW-1:0]          stab_q  [CH];
    logic [CNT_W-1:0]       len_q   [CH];
    state_t                 state_q [CH];

    logic [CH-1:0]   s;
    logic [CH-1:0]   toggle;
    logic [CH-1:0]   valid_nxt;
    logic [2*CH-1:0] class_nxt;
    logic [PW-1:0]   car_cnt;
    logic [TOT_W:0]  car_sum;

    // A toggle while db_out is high is a pulse end; classify it from the
    // length accumulated so far so det_valid and car_total move on that edge.
    always_comb begin
        s         = '0;
        toggle    = '0;
        valid_nxt = '0;
        class_nxt = det_class;
        car_cnt   = '0;
        for (int i = 0; i < CH; i++) begin
            s[i]      = sync_q[i][SYNC_STAGES-1];
            toggle[i] = (s[i] != db_out[i]) && (stab_q[i] == STAB_LAST);
            if (toggle[i] && db_out[i]) begin
                if (state_q[i] == FAULT) begin
                    valid_nxt[i]        = 1'b1;
                    class_nxt[2*i +: 2] = 2'b11;
                end else if ((state_q[i] == MEAS) && (len_q[i] >= CNT_W'(MIN_LEN))) begin
                    valid_nxt[i]        = 1'b1;
                    class_nxt[2*i +: 2] = (len_q[i] >= CNT_W'(CAR_MIN)) ? 2'b10 : 2'b01;
                end
            end
            if (valid_nxt[i] && (class_nxt[2*i +: 2] == 2'b10)) begin
                car_cnt = car_cnt + PW'(1);
            end
        end
        car_sum = {1'b0, car_total} + (TOT_W+1)'(car_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            db_out    <= '0;
            det_valid <= '0;
            det_class <= '0;
            stuck     <= '0;
            car_total <= '0;
            for (int i = 0; i < CH; i++) begin
                sync_q[i]  <= '0;
                stab_q[i]  <= '0;
                len_q[i]   <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            det_valid <= valid_nxt;
            det_class <= class_nxt;

            if (cnt_clr) begin
                car_total <= '0;
            end else if (car_sum > TOT_MAX) begin
                car_total <= '1;
            end else begin
                car_total <= car_sum[TOT_W-1:0];
            end

            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], in[i]};

                if (toggle[i]) begin
                    db_out[i] <= ~db_out[i];
                    stab_q[i] <= '0;
                end else if (s[i] != db_out[i]) begin
                    stab_q[i] <= stab_q[i] + SW'(1);
                end else begin
                    stab_q[i] <= '0;
                end

                // In MEAS/FAULT db_out is high, so any toggle is the falling edge.
                case (state_q[i])
                    IDLE: begin
                        if (toggle[i] && !db_out[i]) begin
                            state_q[i] <= MEAS;
                            len_q[i]   <= CNT_W'(1);
                        end
                    end
                    MEAS: begin
                        if (toggle[i]) begin
                            state_q[i] <= IDLE;
                        end else if (len_q[i] == CNT_W'(MAX_LEN)) begin
                            state_q[i] <= FAULT;
                            stuck[i]   <= 1'b1;
                            len_q[i]   <= CNT_W'(MAX_LEN + 1);
                        end else begin
                            len_q[i] <= len_q[i] + CNT_W'(1);
                        end
                    end
                    FAULT: begin
                        if (toggle[i]) begin
                            state_q[i] <= IDLE;
                            stuck[i]   <= 1'b0;
                        end
                    end
                    default: state_q[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debouncer_classifier_n.sv
// Directed bench for debouncer_classifier_n with hand-computed expectations.
module tb_debouncer_classifier_n;

    localparam int CH    = 4;
    localparam int TOT_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cnt_clr;
    logic [CH-1:0]     in_sig;
    logic [CH-1:0]     db_out;
    logic [CH-1:0]     det_valid;
    logic [2*CH-1:0]   det_class;
    logic [CH-1:0]     stuck;
    logic [TOT_W-1:0]  car_total;

    int checks    = 0;
    int errors    = 0;
    int dv_total  = 0;
    int db0_total = 0;
    int dv_base;
    int db0_base;

    debouncer_classifier_n dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_sig),
        .cnt_clr   (cnt_clr),
        .db_out    (db_out),
        .det_valid (det_valid),
        .det_class (det_class),
        .stuck     (stuck),
        .car_total (car_total)
    );

    always #5 clk = ~clk;

    // Running tallies let a window be checked for stray det_valid / db_out[0].
    always @(negedge clk) begin
        if (det_valid != '0) dv_total <= dv_total + 1;
        if (db_out[0] === 1'b1) db0_total <= db0_total + 1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] mask, input int width);
        in_sig = in_sig | mask;
        tick(width);
        in_sig = in_sig & ~mask;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    int         sw_width [5] = '{1, 2, 5, 6, 10};
    logic [1:0] sw_class [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
    logic       sw_valid [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        rst_n   = 1'b1;
        cnt_clr = 1'b0;
        in_sig  = 4'hF;

        tick(1);
        dv_base = dv_total;
        tick(2);
        checkOutput("rst_db",    32'(db_out),    32'h0);
        checkOutput("rst_dv",    32'(det_valid), 32'h0);
        checkOutput("rst_class", 32'(det_class), 32'h0);
        checkOutput("rst_stuck", 32'(stuck),     32'h0);
        checkOutput("rst_total", 32'(car_total), 32'h0);
        rst_n = 1'b0;
        tick(3);
        checkOutput("rise_lat3", 32'(db_out), 32'h0);
        tick(1);
        checkOutput("rise_lat4", 32'(db_out), 32'hF);
        checkOutput("rise_no_dv", 32'(dv_total - dv_base), 32'h0);

        rst_n  = 1'b1;
        in_sig = 4'h0;
        tick(2);
        rst_n = 1'b0;
        tick(2);

        dv_base  = dv_total;
        db0_base = db0_total;
        applyStimulus(4'b0001, 1);
        tick(8);
        checkOutput("glitch_db",    32'(db0_total - db0_base), 32'h0);
        checkOutput("glitch_no_dv", 32'(dv_total - dv_base),   32'h0);

        applyStimulus(4'b0001, 2);
        tick(1);
        checkOutput("w2_db_e3", 32'(db_out[0]), 32'h0);
        tick(1);
        checkOutput("w2_db_e4", 32'(db_out[0]), 32'h1);
        tick(1);
        checkOutput("w2_db_e5", 32'(db_out[0]), 32'h1);
        tick(1);
        checkOutput("w2_db_e6",  32'(db_out[0]),      32'h0);
        checkOutput("w2_dv",     32'(det_valid),      32'h1);
        checkOutput("w2_class",  32'(det_class[1:0]), 32'h1);
        tick(1);
        checkOutput("w2_dv_once", 32'(det_valid), 32'h0);
        tick(4);

        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0010, sw_width[k]);
            tick(3);
            checkOutput($sformatf("sweep_w%0d_early", sw_width[k]), 32'(det_valid), 32'h0);
            tick(1);
            checkOutput($sformatf("sweep_w%0d_valid", sw_width[k]), 32'(det_valid), 32'(sw_valid[k]) << 1);
            checkOutput($sformatf("sweep_w%0d_class", sw_width[k]), 32'(det_class[3:2]), 32'(sw_class[k]));
            tick(1);
            checkOutput($sformatf("sweep_w%0d_once", sw_width[k]), 32'(det_valid), 32'h0);
            tick(4);
        end

        applyStimulus(4'b0010, 11);
        tick(2);
        checkOutput("w11_stuck_e13", 32'(stuck), 32'h0);
        tick(1);
        checkOutput("w11_stuck_e14", 32'(stuck),     32'h2);
        checkOutput("w11_dv_e14",    32'(det_valid), 32'h0);
        tick(1);
        checkOutput("w11_stuck_fall", 32'(stuck),          32'h0);
        checkOutput("w11_dv",         32'(det_valid),      32'h2);
        checkOutput("w11_class",      32'(det_class[3:2]), 32'h3);
        checkOutput("sweep_total",    32'(car_total),      32'd2);
        tick(4);

        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        checkOutput("clr_total", 32'(car_total), 32'h0);
        applyStimulus(4'hF, 7);
        tick(3);
        checkOutput("simul_pre_dv",    32'(det_valid), 32'h0);
        checkOutput("simul_pre_total", 32'(car_total), 32'h0);
        tick(1);
        checkOutput("simul_dv",    32'(det_valid), 32'hF);
        checkOutput("simul_class", 32'(det_class), 32'hAA);
        checkOutput("simul_total", 32'(car_total), 32'd4);
        tick(4);

        for (int r = 0; r < 62; r++) begin
            applyStimulus(4'hF, 7);
            tick(8);
        end
        applyStimulus(4'b0011, 7);
        tick(8);
        checkOutput("preload_254", 32'(car_total), 32'd254);

        applyStimulus(4'b1100, 7);
        tick(4);
        checkOutput("sat_dv",    32'(det_valid), 32'hC);
        checkOutput("sat_total", 32'(car_total), 32'd255);
        tick(4);
        applyStimulus(4'b0001, 7);
        tick(8);
        checkOutput("sat_hold", 32'(car_total), 32'd255);

        applyStimulus(4'b0001, 7);
        tick(3);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        checkOutput("clr_car_dv",    32'(det_valid),      32'h1);
        checkOutput("clr_car_class", 32'(det_class[1:0]), 32'h2);
        checkOutput("clr_car_total", 32'(car_total),      32'h0);
        tick(4);

        dv_base   = dv_total;
        in_sig[2] = 1'b1;
        tick(15);
        checkOutput("mid_stuck_pre", 32'(stuck), 32'h4);
        rst_n = 1'b1;
        tick(1);
        checkOutput("mid_rst_stuck", 32'(stuck),     32'h0);
        checkOutput("mid_rst_db",    32'(db_out),    32'h0);
        checkOutput("mid_rst_dv",    32'(det_valid), 32'h0);
        checkOutput("mid_rst_class", 32'(det_class), 32'h0);
        rst_n = 1'b0;
        tick(3);
        checkOutput("mid_rise_e3", 32'(db_out), 32'h0);
        tick(1);
        checkOutput("mid_rise_e4", 32'(db_out), 32'h4);
        tick(1);
        in_sig[2] = 1'b0;
        tick(3);
        checkOutput("mid_no_dv", 32'(dv_total - dv_base), 32'h0);
        tick(1);
        checkOutput("mid_new_dv",    32'(det_valid),      32'h4);
        checkOutput("mid_new_class", 32'(det_class[5:4]), 32'h1);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debouncer_classifier_n.md
Name: debouncer_classifier_n

Overview:
- Multi-channel successor to the single-input parking debouncer.
- Each channel synchronises a raw tyre-sensor input, glitch-filters it and measures the filtered high-pulse length in clock cycles.
- On each pulse end it classifies the pulse as bicycle, car or stuck/fault.
- A shared saturating counter totals car detections across all channels for the parking-occupancy logic.

Parameters:
- CH, 4: number of independent sensor channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- STABLE_CNT, 2: consecutive differing samples required before the filtered output toggles (≥1).
- CNT_W, 4: pulse-length counter width; requires MAX_LEN+1 ≤ 2^CNT_W-1.
- MIN_LEN, 2: shortest valid pulse; shorter pulses are discarded.
- CAR_MIN, 6: shortest pulse classed as car; MIN_LEN < CAR_MIN ≤ MAX_LEN.
- MAX_LEN, 10: longest valid pulse; longer pulses are fault.
- TOT_W, 8: width of car_total.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst_n, input, 1: synchronous, active-high reset (asserted = 1 resets). The name is kept for codebase consistency.
- in, input, CH: raw asynchronous sensor inputs, one bit per channel.
- cnt_clr, input, 1: synchronous clear of car_total.
- db_out, output, CH: filtered level per channel.
- det_valid, output, CH: one-cycle pulse per channel when a classified pulse ends.
- det_class, output, 2*CH: per-channel class, bits [2i+1:2i]. 00 = none, 01 = bike, 10 = car, 11 = fault. Holds its value until the next det_valid on that channel.
- stuck, output, CH: high while the current pulse length exceeds MAX_LEN.
- car_total, output, TOT_W: saturating total of car detections.

Behaviour:
- Reset (rst_n=1 at an edge) clears every flop:
  - db_out=0, det_valid=0, det_class=0, stuck=0, car_total=0.
  - Synchronisers, stability counters and length counters also clear.
  - A pulse in progress is discarded with no det_valid. An input held high through reset is treated as a new rising edge after the normal latency.
- Synchroniser: in[i] shifts through SYNC_STAGES flops. The last stage is s[i].
- Glitch filter, per channel, counter stab:
  - At each edge where s[i] != db_out[i], stab increments.
  - When stab == STABLE_CNT-1 and s[i] != db_out[i] at an edge, db_out[i] toggles and stab clears.
  - At any edge where s[i] == db_out[i], stab clears.
  - Rise and fall latency from in to db_out is SYNC_STAGES+STABLE_CNT edges (4 by default), so pulse width is preserved.
- Length FSM, per channel, with states IDLE, MEAS and FAULT:
  - IDLE to MEAS: on the edge where db_out rises; len is loaded with 1.
  - MEAS: len increments at each edge while db_out stays 1.
  - MEAS to FAULT: when len would become MAX_LEN+1. stuck asserts on that same edge, and len saturates from then on.
  - Falling edge of db_out: return to IDLE. On that edge, with L = cycles db_out was high:
    - L < MIN_LEN: no det_valid; det_class unchanged.
    - MIN_LEN ≤ L < CAR_MIN: det_valid=1, class 01.
    - CAR_MIN ≤ L ≤ MAX_LEN: det_valid=1, class 10.
    - From FAULT: det_valid=1, class 11, and stuck clears on the same edge.
  - det_valid is high for exactly one cycle. Channels are fully independent.
- car_total:
  - At each edge it adds the number of channels with det_valid=1 and class 10 on that edge (popcount, 0..CH).
  - Saturates at 2^TOT_W-1 and never wraps.
  - Priority: rst_n > cnt_clr > increment. If cnt_clr and detections coincide, the result is 0.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles with in=4'hF, release -> all outputs 0 during reset. db_out=4'hF exactly 4 edges after release. No det_valid.
- Glitch: in[0] high for 1 cycle -> db_out[0] stays 0, no det_valid. in[0] high for exactly 2 cycles -> db_out[0] high 2 cycles, det_valid[0] pulse with class 01.
- Classification sweep on ch1 with widths 1, 2, 5, 6, 10, 11 -> respectively none, bike, bike, car, car, fault. For width 11, stuck[1] rises on the 11th high edge and clears at the fall. car_total ends at 2.
- Simultaneous: four 7-cycle pulses aligned on all channels -> det_valid=4'hF in the same cycle, every class 10, car_total steps 0->4 in one edge.
- Saturation and clear, with TOT_W=8:
  - Preload to 254, then two simultaneous cars -> car_total=255.
  - A further car -> stays 255.
  - cnt_clr asserted in the same cycle as a car det_valid -> car_total=0.
- Mid-pulse reset: assert rst_n during a 20-cycle FAULT pulse on ch2 -> stuck[2] clears at the reset edge and no det_valid appears. After release with in still high, measurement restarts from the new rise.
